// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter
//   Shares one fixed-latency, non-stallable FP16 multiplier core among NREQ
//   requesters. Round-robin grant, registered issue to the core, a tag pipe
//   that re-associates each core result with its requester ID, and a
//   first-word-fall-through result FIFO drained over one valid/ready channel.
//   Issue is credit-limited so the FIFO can never overflow.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset (shared with core)
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b           packed operands, requester i in bits [16i+15:16i]
//   mul_valid/mul_a/mul_b  registered issue to the core
//   mul_valid_out          core result strobe, LAT cycles after mul_valid
//   mul_result, mul_flags  core result and {overflow, zero, NaN, precisionLost}
//   rsp_valid/rsp_ready    shared response handshake (FIFO head)
//   rsp_id/result/flags    head entry contents (zero while empty)
//   err                    sticky: core strobe and tag pipe disagreed
//   inflight               operations issued and not yet out of the core
module fp16_mul_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 4,
   parameter int unsigned OUTQ = 8,
   parameter int unsigned IDW  = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [16*NREQ-1:0]         req_a,
   input  logic [16*NREQ-1:0]         req_b,
   output logic                       mul_valid,
   output logic [15:0]                mul_a,
   output logic [15:0]                mul_b,
   input  logic                       mul_valid_out,
   input  logic [15:0]                mul_result,
   input  logic [3:0]                 mul_flags,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [IDW-1:0]             rsp_id,
   output logic [15:0]                rsp_result,
   output logic [3:0]                 rsp_flags,
   output logic                       err,
   output logic [$clog2(LAT+1)-1:0]   inflight
);

   // The tag pipe spans LAT+1 cycles, so up to LAT+1 ops can be counted.
   localparam int unsigned IFW  = $clog2(LAT+2);
   localparam int unsigned OCW  = $clog2(OUTQ+1);
   localparam int unsigned PW   = (OUTQ > 1) ? $clog2(OUTQ) : 1;
   localparam int unsigned ENTW = IDW + 16 + 4;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [IDW-1:0]          ptr_q;
   logic [IFW-1:0]          inflight_q;
   logic [OCW-1:0]          occ_q;
   logic [LAT:0]            tag_v_q;
   logic [LAT:0][IDW-1:0]   tag_id_q;
   logic                    mul_valid_q;
   logic [15:0]             mul_a_q;
   logic [15:0]             mul_b_q;
   logic                    err_q;
   logic [PW-1:0]           wr_ptr_q;
   logic [PW-1:0]           rd_ptr_q;
   logic [ENTW-1:0]         mem [OUTQ];

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic                    credit;
   logic                    issue;
   logic [NREQ-1:0]         grant_oh;
   logic [IDW-1:0]          grant_idx;
   int unsigned             scan_idx;
   logic                    tag_out_v;
   logic [IDW-1:0]          tag_out_id;
   logic                    push;
   logic                    pop;
   logic [ENTW-1:0]         head;

   assign credit     = (32'(inflight_q) + 32'(occ_q)) < OUTQ;
   assign tag_out_v  = tag_v_q[LAT];
   assign tag_out_id = tag_id_q[LAT];
   assign push       = mul_valid_out & tag_out_v;
   assign rsp_valid  = (occ_q != '0);
   assign pop        = rsp_valid & rsp_ready;
   assign head       = mem[rd_ptr_q];

   // Round-robin search starting at ptr_q, wrapping at NREQ.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      issue     = 1'b0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_idx = 32'(ptr_q) + i;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
         if (credit && !issue && req_valid[scan_idx]) begin
            issue              = 1'b1;
            grant_idx          = IDW'(scan_idx);
            grant_oh[scan_idx] = 1'b1;
         end
      end
   end

   assign req_ready = grant_oh;

   // ---------------------------------------------------------------------
   // Round-robin pointer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else if (issue) begin
         if (32'(grant_idx) == NREQ - 1) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= grant_idx + IDW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Issue registers; operands hold when idle
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mul_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         mul_valid_q <= issue;
         if (issue) begin
            mul_a_q <= req_a[32'(grant_idx)*16 +: 16];
            mul_b_q <= req_b[32'(grant_idx)*16 +: 16];
         end
      end
   end

   assign mul_valid = mul_valid_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

   // ---------------------------------------------------------------------
   // Tag pipe: entered in the grant cycle, so its last stage lines up with
   // mul_valid_out (one register cycle of issue plus LAT of core).
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tag_v_q  <= '0;
         tag_id_q <= '0;
      end else begin
         tag_v_q  <= {tag_v_q[LAT-1:0], issue};
         tag_id_q <= {tag_id_q[LAT-1:0], grant_idx};
      end
   end

   // ---------------------------------------------------------------------
   // In-flight counter. The decrement follows the tag leaving the pipe, so
   // a spurious core strobe cannot underflow it and a missing strobe does
   // not leak a credit; in normal operation both coincide.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         inflight_q <= '0;
      end else begin
         unique case ({issue, tag_out_v})
            2'b10:   inflight_q <= inflight_q + IFW'(1);
            2'b01:   inflight_q <= inflight_q - IFW'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   assign inflight = inflight_q[$clog2(LAT+1)-1:0];

   // ---------------------------------------------------------------------
   // Sticky protocol error
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if (mul_valid_out != tag_out_v) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;

   // ---------------------------------------------------------------------
   // Result FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {tag_out_id, mul_result, mul_flags};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            if (32'(wr_ptr_q) == OUTQ - 1) begin
               wr_ptr_q <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_q + PW'(1);
            end
         end
         if (pop) begin
            if (32'(rd_ptr_q) == OUTQ - 1) begin
               rd_ptr_q <= '0;
            end else begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
         end
         unique case ({push, pop})
            2'b10:   occ_q <= occ_q + OCW'(1);
            2'b01:   occ_q <= occ_q - OCW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Head fields are forced to zero while empty so outputs stay defined.
   assign rsp_id     = rsp_valid ? head[ENTW-1 -: IDW] : '0;
   assign rsp_result = rsp_valid ? head[19:4]          : '0;
   assign rsp_flags  = rsp_valid ? head[3:0]           : '0;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
module tb_fp16_mul_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int OUTQ = 8;
   localparam int IDW  = 2;

   logic                     clk = 1'b0;
   logic                     rstn;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [16*NREQ-1:0]       req_a;
   logic [16*NREQ-1:0]       req_b;
   logic                     mul_valid;
   logic [15:0]              mul_a;
   logic [15:0]              mul_b;
   logic                     mul_valid_out;
   logic [15:0]              mul_result;
   logic [3:0]               mul_flags;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [IDW-1:0]           rsp_id;
   logic [15:0]              rsp_result;
   logic [3:0]               rsp_flags;
   logic                     err;
   logic [$clog2(LAT+1)-1:0] inflight;
   logic                     spur;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fp16_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .OUTQ(OUTQ), .IDW(IDW)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_valid_out(mul_valid_out), .mul_result(mul_result), .mul_flags(mul_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .err(err), .inflight(inflight)
   );

   // Simplified FP16 multiply: returns {flags, result}; subnormals flush to zero.
   function automatic logic [19:0] fpmul(input logic [15:0] a, input logic [15:0] b);
      logic       s;
      logic [4:0] ea, eb;
      logic [9:0] ma, mb, fr;
      logic [21:0] m;
      logic       lost;
      int         e;
      s  = a[15] ^ b[15];
      ea = a[14:10]; eb = b[14:10];
      ma = a[9:0];   mb = b[9:0];
      if ((ea == 5'h1F && ma != 0) || (eb == 5'h1F && mb != 0)) return {4'b0010, 16'h7E00};
      if (ea == 0 || eb == 0) return {4'b0100, s, 15'h0};
      if (ea == 5'h1F || eb == 5'h1F) return {4'b1000, s, 5'h1F, 10'h0};
      m = {1'b1, ma} * {1'b1, mb};
      e = int'(ea) + int'(eb) - 15;
      if (m[21]) begin
         lost = |m[10:0]; fr = m[20:11]; e = e + 1;
      end else begin
         lost = |m[9:0];  fr = m[19:10];
      end
      if (e >= 31) return {4'b1000, s, 5'h1F, 10'h0};
      if (e <= 0)  return {4'b0100, s, 15'h0};
      return {3'b000, lost, s, e[4:0], fr};
   endfunction

   // Behavioural core: fixed LAT-cycle pipe, shares rstn.
   logic [LAT-1:0] cv;
   logic [15:0]    cr [LAT];
   logic [3:0]     cf [LAT];
   logic [19:0]    core_in;
   assign core_in = fpmul(mul_a, mul_b);

   always @(posedge clk) begin
      if (!rstn) cv <= '0;
      else       cv <= {cv[LAT-2:0], mul_valid};
      cr[0] <= core_in[15:0];
      cf[0] <= core_in[19:16];
      for (int k = 1; k < LAT; k++) begin
         cr[k] <= cr[k-1];
         cf[k] <= cf[k-1];
      end
   end

   assign mul_valid_out = cv[LAT-1] | spur;
   assign mul_result    = cr[LAT-1];
   assign mul_flags     = cf[LAT-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_mid();
      @(negedge clk);
   endtask

   // Leaves the caller at the start of the first post-reset cycle.
   task automatic do_reset();
      cyc_start();
      rstn = 1'b0; req_valid = '0; rsp_ready = 1'b0; spur = 1'b0;
      cyc_start();
      cyc_start();
      rstn = 1'b1;
   endtask

   typedef struct {
      int          id;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  fl;
   } vec_t;

   typedef struct {
      int          id;
      logic [15:0] res;
      logic [3:0]  fl;
      int          vis;
   } exp_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      exp_t q[$];
      logic [15:0] opa [NREQ];
      logic [15:0] opb [NREQ];
      logic [19:0] r;
      logic [NREQ-1:0] exp_rr;
      int nr, mv_cnt, mv_first, mv_last, nissue, stale, mptr, g, idx, einf;
      logic erv;

      vt[0] = '{2, 16'h3C00, 16'h4000, 16'h4000, 4'h0};
      vt[1] = '{1, 16'h7C01, 16'h3C00, 16'h7E00, 4'h2};
      vt[2] = '{0, 16'h3E00, 16'h3E00, 16'h4080, 4'h0};
      vt[3] = '{3, 16'hBC00, 16'h3C00, 16'hBC00, 4'h0};
      vt[4] = '{0, 16'h0000, 16'h3C00, 16'h0000, 4'h4};
      vt[5] = '{2, 16'h7800, 16'h7800, 16'h7C00, 4'h8};

      rstn = 1'b0; req_valid = '0; rsp_ready = 1'b0; spur = 1'b0;
      req_a = '0; req_b = '0;

      // ---- reset state and single-op table ----
      do_reset();
      cyc_mid();
      chk("rst_mul_valid", mul_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_req_ready", req_ready, 0);

      foreach (vt[v]) begin
         cyc_start();
         req_valid = '0;
         req_valid[vt[v].id] = 1'b1;
         req_a[vt[v].id*16 +: 16] = vt[v].a;
         req_b[vt[v].id*16 +: 16] = vt[v].b;
         rsp_ready = 1'b1;
         cyc_mid();
         chk("tbl_req_ready", req_ready, 32'(1) << vt[v].id);
         cyc_start();
         req_valid = '0;
         cyc_mid();
         chk("tbl_mul_valid", mul_valid, 1);
         chk("tbl_mul_a", mul_a, vt[v].a);
         chk("tbl_mul_b", mul_b, vt[v].b);
         for (int k = 2; k <= 7; k++) begin
            cyc_start();
            cyc_mid();
            if (k == 2) begin
               chk("tbl_mul_idle", mul_valid, 0);
               chk("tbl_mul_a_hold", mul_a, vt[v].a);
            end
            if (k == 5) chk("tbl_rsp_early", rsp_valid, 0);
            if (k == 6) begin
               chk("tbl_rsp_valid", rsp_valid, 1);
               chk("tbl_rsp_id", rsp_id, vt[v].id);
               chk("tbl_rsp_result", rsp_result, vt[v].res);
               chk("tbl_rsp_flags", rsp_flags, vt[v].fl);
            end
            if (k == 7) begin
               chk("tbl_rsp_drained", rsp_valid, 0);
               chk("tbl_inflight", inflight, 0);
            end
         end
      end

      // ---- round-robin fairness ----
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = 16'h3C00 + 16'(i << 8);
         opb[i] = 16'h4000;
         req_a[i*16 +: 16] = opa[i];
         req_b[i*16 +: 16] = opb[i];
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      nr = 0; mv_cnt = 0; mv_first = -1; mv_last = -1;
      for (int c = 0; c < 25; c++) begin
         if (c > 0) cyc_start();
         if (c == 6) req_valid = '0;
         cyc_mid();
         if (c < 6) chk("rr_grant", req_ready, 32'(1) << (c % NREQ));
         if (mul_valid) begin
            mv_cnt++;
            if (mv_first < 0) mv_first = c;
            mv_last = c;
         end
         if (rsp_valid) begin
            r = fpmul(opa[nr % NREQ], opb[nr % NREQ]);
            chk("rr_rsp_id", rsp_id, nr % NREQ);
            chk("rr_rsp_result", rsp_result, r[15:0]);
            nr++;
         end
      end
      chk("rr_mul_valid_count", mv_cnt, 6);
      chk("rr_mul_valid_span", mv_last - mv_first + 1, 6);
      chk("rr_rsp_count", nr, 6);

      // ---- backpressure ----
      do_reset();
      req_valid = '1;
      rsp_ready = 1'b0;
      nissue = 0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) cyc_start();
         cyc_mid();
         if (req_ready != 0) nissue++;
      end
      chk("bp_issue_count", nissue, OUTQ);
      chk("bp_req_ready_blocked", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_inflight", inflight, 0);
      nr = 0;
      for (int c = 0; c < 50; c++) begin
         cyc_start();
         if (c == 0) rsp_ready = 1'b1;
         if (c == 2) req_valid = '0;
         cyc_mid();
         if (c == 0) chk("bp_no_issue_on_pop", req_ready, 0);
         if (c == 1) chk("bp_issue_after_pop", req_ready, 4'b0001);
         if (rsp_valid && rsp_ready) begin
            idx = (nr < OUTQ) ? (nr % NREQ) : 0;
            r = fpmul(opa[idx], opb[idx]);
            chk("bp_rsp_id", rsp_id, idx);
            chk("bp_rsp_result", rsp_result, r[15:0]);
            nr++;
         end
      end
      chk("bp_rsp_count", nr, OUTQ + 1);
      chk("bp_drained", rsp_valid, 0);

      // ---- reset mid-flight ----
      do_reset();
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) cyc_start();
         if (c == 3) req_valid = '0;
         if (c == 4) rstn = 1'b0;
         cyc_mid();
      end
      cyc_start();
      rstn = 1'b1;
      cyc_mid();
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_inflight", inflight, 0);
      chk("mid_rst_err", err, 0);
      stale = 0;
      for (int c = 0; c < 15; c++) begin
         cyc_start();
         cyc_mid();
         if (rsp_valid || err) stale++;
      end
      chk("mid_rst_no_stale", stale, 0);
      cyc_start();
      req_valid = '1;
      cyc_mid();
      chk("mid_rst_ptr_zero", req_ready, 4'b0001);
      cyc_start();
      req_valid = '0;

      // ---- spurious core result ----
      do_reset();
      spur = 1'b1;
      cyc_mid();
      chk("spur_err_before", err, 0);
      cyc_start();
      spur = 1'b0;
      cyc_mid();
      chk("spur_err_set", err, 1);
      chk("spur_no_push", rsp_valid, 0);
      chk("spur_inflight", inflight, 0);
      repeat (5) begin
         cyc_start();
         cyc_mid();
      end
      chk("spur_err_sticky", err, 1);
      chk("spur_still_empty", rsp_valid, 0);

      // ---- randomized traffic against a queue model ----
      do_reset();
      mptr = 0;
      q.delete();
      for (int c = 0; c < 600; c++) begin
         if (c > 0) cyc_start();
         for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = ($urandom_range(0, 3) != 0);
            req_a[i*16 +: 16] = 16'($urandom);
            req_b[i*16 +: 16] = 16'($urandom);
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         cyc_mid();
         g = -1;
         if (q.size() < OUTQ) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (mptr + k) % NREQ;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         exp_rr = (g >= 0) ? NREQ'(1 << g) : '0;
         chk("rnd_req_ready", req_ready, exp_rr);
         erv = (q.size() > 0) && (q[0].vis <= c);
         chk("rnd_rsp_valid", rsp_valid, erv);
         einf = 0;
         foreach (q[j]) if (q[j].vis > c) einf++;
         chk("rnd_inflight", inflight, einf);
         if (erv && rsp_ready) begin
            chk("rnd_rsp_id", rsp_id, q[0].id);
            chk("rnd_rsp_result", rsp_result, q[0].res);
            chk("rnd_rsp_flags", rsp_flags, q[0].fl);
            void'(q.pop_front());
         end
         if (g >= 0) begin
            r = fpmul(req_a[g*16 +: 16], req_b[g*16 +: 16]);
            q.push_back('{g, r[15:0], r[19:16], c + LAT + 2});
            mptr = (g + 1) % NREQ;
         end
      end
      chk("rnd_err_clear", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Shares one 4-cycle pipelined FP16 multiplier core among NREQ requesters using round-robin arbitration.
- Tags each issued operation with its requester ID and tracks it through the core's fixed-latency, non-stallable pipeline.
- Buffers results in an output FIFO and returns them on one shared response channel with valid/ready handshake.
- Sits between the vector/MAC front-ends and the multiplier core; the core is instantiated beside this block, not inside it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 4, core latency in cycles from mul_valid asserted to mul_valid_out.
- OUTQ, 8, output FIFO depth and total credit count (must be >= LAT).
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  16*NREQ  operand A, requester i in bits [16i+15:16i]
- req_b  in  16*NREQ  operand B, same packing as req_a
- mul_valid  out  1  issue strobe to the core
- mul_a  out  16  operand A to the core
- mul_b  out  16  operand B to the core
- mul_valid_out  in  1  core result valid
- mul_result  in  16  core result
- mul_flags  in  4  core flags {overflow, zero, NaN, precisionLost}
- rsp_valid  out  1  response valid (FIFO head)
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester ID of the head response
- rsp_result  out  16  head result
- rsp_flags  out  4  head flags
- err  out  1  sticky protocol error
- inflight  out  clog2(LAT+1)  operations currently inside the core

Behaviour:
- Reset: clk and rstn are decided as stated: synchronous, active-low reset rstn; clock clk.
- All outputs reset to 0: mul_valid, rsp_valid, err and inflight are 0.
- Reset clears the round-robin pointer to 0, the FIFO, the counters and the tag pipe.
- Reset mid-operation discards all in-flight and queued results; the core shares rstn.
- Credit rule: issue is allowed iff inflight + occ < OUTQ, using registered values.
  - occ is the FIFO occupancy.
  - A pop in cycle t frees credit from cycle t+1.
- Arbitration:
  - When credit is available, grant the first requester with req_valid=1, searching from ptr upward with wrap-around.
  - req_ready = grant (one-hot), combinational from req_valid, ptr and credit.
  - At most one issue per cycle.
  - On issue, ptr <= granted index + 1, wrapping at NREQ; otherwise ptr holds.
- Issue path:
  - mul_valid, mul_a and mul_b are registered.
  - A handshake in cycle t gives mul_valid=1 in cycle t+1 carrying that requester's operands.
  - mul_valid is 0 when there is no issue; mul_a and mul_b hold their last values.
- Tag tracking: a LAT+1-deep shift pipe of {valid, id} aligned so that its output coincides with mul_valid_out.
- Counters:
  - inflight: +1 on issue, -1 on mul_valid_out; simultaneous events leave it unchanged.
  - occ: +1 on push, -1 on pop; simultaneous events leave it unchanged.
- Push: on mul_valid_out, write {tag id, mul_result, mul_flags} into the FIFO.
- Protocol errors:
  - If mul_valid_out=1 while the tag-pipe output is invalid, or the tag-pipe output is valid with mul_valid_out=0, set err=1.
  - In the first case the result is dropped.
  - err clears only on reset.
- FIFO: first-word-fall-through; rsp_* present the head whenever occ > 0.
- Pop: on rsp_valid && rsp_ready.
- Push to an empty FIFO: visible on rsp_valid the next cycle.
- Overflow is impossible by the credit rule; push and pop on a full FIFO both proceed.
- Ordering: responses leave in issue order, matching the core's in-order pipeline.
- Latency: request accepted at t -> rsp_valid at t+LAT+2 when the FIFO is empty and rsp_ready=1.
- Throughput: 1 operation/cycle sustained while rsp_ready stays high.
- When no requester is valid, the pipeline drains and mul_valid stays 0.

Test Plan:
- Single op: requester 2 sends a=0x3C00, b=0x4000 at t=0, rsp_ready=1 -> req_ready=4'b0100 at t=0; rsp_valid at t=6 with rsp_id=2, rsp_result=0x4000, rsp_flags=0; inflight returns to 0.
- Round-robin fairness: all 4 requesters hold valid from reset -> grants 0,1,2,3,0,1 on consecutive cycles; responses return in the same ID order; mul_valid is high for 6 consecutive cycles.
- Backpressure: rsp_ready=0 while all requesters stay valid -> exactly 8 issues, then req_ready=0; no FIFO loss. Raise rsp_ready=1 -> first pop; the next issue happens one cycle later; all 8 results drain in order.
- Flags passthrough: requester 1 sends 0x7C01 × 0x3C00 -> rsp_flags has the NaN bit set, rsp_id=1.
- Reset mid-flight: three operations issued, rstn low for 1 cycle before any result -> rsp_valid, inflight and err are 0 after reset; no stale response appears later; ptr restarts at 0.
- Spurious result: force mul_valid_out=1 with nothing in flight -> err=1 the next cycle and stays 1; FIFO occ unchanged.
